serial_add_ctrl: RTL and testbench

Bit-serial addition controller that sits directly upstream of the single-bit `full_adder` in the serial adder datapath. It captures two WIDTH-bit operands, feeds them LSB-first into the external full adder one bit per clock, and keeps the carry in a flip-flop between bits. It also shifts the returned sum bits into a result register. A start/busy/done handshake frames each operation, so the serial adder can be driven like a multi-cycle arithmetic unit.

---
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller driving an external single-bit full adder.
// Optional signed overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == SHIFT) && (cnt == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == SHIFT) begin
      fa_a   = a_sr[0];
      fa_b   = b_sr[0];
      fa_cin = carry_q;
    end
  end

  // Operands shift right so the adder always sees the current bit at [0];
  // sum fills from the top so bit 0 lands at sum[0] after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sr    <= op_a;
      b_sr    <= op_b;
      carry_q <= cin;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state_q == SHIFT) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      sum     <= {fa_sum, sum[WIDTH-1:1]};
      carry_q <= fa_cout;
      if (last_bit) cout <= fa_cout;
      else          cnt  <= cnt + CW'(1);
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Two's-complement overflow: carry into the MSB differs from carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        overflow <= 1'b0;
    else if (accept)   overflow <= 1'b0;
    else if (last_bit) overflow <= fa_cin ^ fa_cout;
  end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed table, start-ignore and
// mid-operation reset sequences, then random operands against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  // External combinational full adder.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer addition of the operands.
  function automatic logic [W:0] model_total(input logic [W-1:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, b, input logic c);
    logic [W:0] t;
    t = model_total(a, b, c);
    return (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
  endfunction

  // Carry entering bit i = carry out of adding the low i bits.
  function automatic logic model_carry_in(input logic [W-1:0] a, b, input logic c, input int i);
    int unsigned mask, t;
    mask = (32'd1 << i) - 32'd1;
    t    = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    return 1'((t >> i) & 1);
  endfunction

  // One full operation, sampled on negedges. pulse_at = cycle index (0..W)
  // at which a spurious start with junk operands is raised; -1 for none.
  task automatic run_op(input logic [W-1:0] a, b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int pulse_at);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      start = 1'b0;
      if (i == 0) begin
        check("sum_cleared", 32'(sum), 32'd0);
        check("cout_cleared", 32'(cout), 32'd0);
      end
      check($sformatf("fa_a_bit%0d", i), 32'(fa_a), 32'(a[i]));
      check($sformatf("fa_b_bit%0d", i), 32'(fa_b), 32'(b[i]));
      check($sformatf("fa_cin_bit%0d", i), 32'(fa_cin), 32'(model_carry_in(a, b, c, i)));
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      if (pulse_at == i) begin
        start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
    check("fa_idle_in_done", 32'({fa_a, fa_b, fa_cin}), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("overflow", 32'(overflow), 32'(eo));
`else
    if (eo === 1'bx) check("ovf_arg_known", 32'(eo), 32'd0);
`endif
    if (pulse_at == W) begin
      start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_idle", 32'(busy), 32'd0);
    check("done_idle", 32'(done), 32'd0);
    check("sum_hold", 32'(sum), 32'(es));
    check("cout_hold", 32'(cout), 32'(ec));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           pulse_at;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, es: 8'h96, ec: 1'b0, eo: 1'b1, pulse_at: -1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, es: 8'h00, ec: 1'b1, eo: 1'b0, pulse_at: -1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, es: 8'hFF, ec: 1'b1, eo: 1'b0, pulse_at: W};
    vecs[3] = '{a: 8'h80, b: 8'h80, c: 1'b0, es: 8'h00, ec: 1'b1, eo: 1'b1, pulse_at: 3};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_overflow", 32'(overflow), 32'd0);
`endif
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].es, vecs[v].ec, vecs[v].eo, vecs[v].pulse_at);

    // Reset during bit 4 of 0x12 + 0x34: everything clears, no done.
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("midrst_overflow", 32'(overflow), 32'd0);
`endif
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, -1);

    // Random operands against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   t;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      t  = model_total(ra, rb, rc);
      run_op(ra, rb, rc, t[W-1:0], t[W], model_ovf(ra, rb, rc),
             (n % 5 == 0) ? int'($urandom_range(0, W)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
